// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and XOR stage: per byte it advances i/j, swaps S[i]/S[j], reads S[S[i]+S[j]]
// and the ciphertext byte, and writes the plaintext through the decrypted-memory start/finish handshake.
module rc4_prga_decrypt #(
    parameter int MSG_LEN  = 32,
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       finish,
    output logic [7:0] s_adr,
    output logic       s_wren,
    output logic [7:0] s_wdata,
    input  logic [7:0] s_rdata,
    output logic [7:0] rom_adr,
    input  logic [7:0] rom_rdata,
    output logic       dec_start,
    input  logic       dec_finish,
    output logic       dec_readWrite,
    output logic [7:0] dec_adr,
    output logic [7:0] dec_wdata
);
    localparam logic [7:0] LAST_K    = 8'(MSG_LEN - 1);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 2);
    localparam bit         HAS_WAIT  = (READ_LAT > 1);

    typedef enum logic [3:0] {
        IDLE, FETCH_I, WAIT_I, GOT_SI, FETCH_J, WAIT_J, GOT_SJ,
        WR_I, FETCH_F, WAIT_F, GOT_F, DEC_REQ, NEXT, DONE
    } state_t;

    state_t     state_q;
    logic [7:0] i_q, j_q, k_q, si_q, sj_q, plain_q;
    logic [1:0] wait_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            plain_q <= '0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= FETCH_I;
                    end
                end
                FETCH_I: begin
                    i_q     <= i_q + 8'd1;
                    wait_q  <= '0;
                    state_q <= HAS_WAIT ? WAIT_I : GOT_SI;
                end
                WAIT_I: begin
                    wait_q <= wait_q + 2'd1;
                    if (wait_q == WAIT_LAST) state_q <= GOT_SI;
                end
                GOT_SI: begin
                    si_q    <= s_rdata;
                    j_q     <= j_q + s_rdata;
                    state_q <= FETCH_J;
                end
                // j depends on the S byte just returned, so its read is issued from j_q one cycle later.
                FETCH_J: begin
                    wait_q  <= '0;
                    state_q <= HAS_WAIT ? WAIT_J : GOT_SJ;
                end
                WAIT_J: begin
                    wait_q <= wait_q + 2'd1;
                    if (wait_q == WAIT_LAST) state_q <= GOT_SJ;
                end
                GOT_SJ: begin
                    sj_q    <= s_rdata;
                    state_q <= WR_I;
                end
                WR_I: state_q <= FETCH_F;
                FETCH_F: begin
                    wait_q  <= '0;
                    state_q <= HAS_WAIT ? WAIT_F : GOT_F;
                end
                WAIT_F: begin
                    wait_q <= wait_q + 2'd1;
                    if (wait_q == WAIT_LAST) state_q <= GOT_F;
                end
                GOT_F: begin
                    plain_q <= s_rdata ^ rom_rdata;
                    state_q <= DEC_REQ;
                end
                DEC_REQ: begin
                    if (dec_finish) state_q <= NEXT;
                end
                NEXT: begin
                    if (k_q == LAST_K) begin
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= FETCH_I;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        finish        = 1'b0;
        s_adr         = '0;
        s_wren        = 1'b0;
        s_wdata       = '0;
        rom_adr       = '0;
        dec_start     = 1'b0;
        dec_readWrite = 1'b0;
        dec_adr       = '0;
        dec_wdata     = '0;
        case (state_q)
            FETCH_I:         s_adr = i_q + 8'd1;
            WAIT_I:          s_adr = i_q;
            FETCH_J, WAIT_J: s_adr = j_q;
            GOT_SJ: begin
                s_adr   = j_q;
                s_wren  = 1'b1;
                s_wdata = si_q;
            end
            WR_I: begin
                s_adr   = i_q;
                s_wren  = 1'b1;
                s_wdata = sj_q;
            end
            FETCH_F, WAIT_F, GOT_F: begin
                s_adr   = si_q + sj_q;
                rom_adr = k_q;
            end
            DEC_REQ: begin
                dec_start     = 1'b1;
                dec_readWrite = 1'b1;
                dec_adr       = k_q;
                dec_wdata     = plain_q;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: three instances (3 bytes/lat 1, 3 bytes/lat 3, 256 bytes/lat 1) with
// S RAM, ROM and decrypted-memory models, checked against a software RC4 reference.
module tb_rc4_prga_decrypt;
    localparam int NI = 3;
    localparam int RLAT [NI] = '{1, 3, 1};
    localparam int MLEN [NI] = '{3, 3, 256};

    logic       clk = 1'b0;
    logic       reset [NI];
    logic       start [NI];
    logic       finish [NI];
    logic [7:0] s_adr [NI];
    logic       s_wren [NI];
    logic [7:0] s_wdata [NI];
    logic [7:0] s_rdata [NI];
    logic [7:0] rom_adr [NI];
    logic [7:0] rom_rdata [NI];
    logic       dec_start [NI];
    logic       dec_finish [NI] = '{1'b0, 1'b0, 1'b0};
    logic       dec_rw [NI];
    logic [7:0] dec_adr [NI];
    logic [7:0] dec_wdata [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rc4_prga_decrypt #(.MSG_LEN(MLEN[g]), .READ_LAT(RLAT[g])) u_dut (
            .clk(clk), .reset(reset[g]), .start(start[g]), .finish(finish[g]),
            .s_adr(s_adr[g]), .s_wren(s_wren[g]), .s_wdata(s_wdata[g]), .s_rdata(s_rdata[g]),
            .rom_adr(rom_adr[g]), .rom_rdata(rom_rdata[g]),
            .dec_start(dec_start[g]), .dec_finish(dec_finish[g]), .dec_readWrite(dec_rw[g]),
            .dec_adr(dec_adr[g]), .dec_wdata(dec_wdata[g])
        );
    end

    // memory and interface models
    logic [7:0] smem [NI][256];
    logic [7:0] init_s [NI][256];
    logic [7:0] rom [NI][256];
    logic [7:0] spipe [NI][3];
    logic [7:0] rpipe [NI][3];
    logic       load [NI];
    int         dly [NI] = '{1, 1, 1};
    int         dcnt [NI] = '{0, 0, 0};
    logic [7:0] wr_adr [NI][1024];
    logic [7:0] wr_dat [NI][1024];
    int         wr_n [NI] = '{0, 0, 0};

    always_comb begin
        for (int u = 0; u < NI; u++) begin
            s_rdata[u]   = spipe[u][RLAT[u] - 1];
            rom_rdata[u] = rpipe[u][RLAT[u] - 1];
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < NI; u++) begin
            spipe[u][0] <= smem[u][s_adr[u]];
            spipe[u][1] <= spipe[u][0];
            spipe[u][2] <= spipe[u][1];
            rpipe[u][0] <= rom[u][rom_adr[u]];
            rpipe[u][1] <= rpipe[u][0];
            rpipe[u][2] <= rpipe[u][1];
            if (load[u]) begin
                for (int a = 0; a < 256; a++) smem[u][a] <= init_s[u][a];
            end else if (s_wren[u]) begin
                smem[u][s_adr[u]] <= s_wdata[u];
            end
            if (dec_start[u] && dec_finish[u]) begin
                wr_adr[u][wr_n[u] % 1024] <= dec_adr[u];
                wr_dat[u][wr_n[u] % 1024] <= dec_wdata[u];
                wr_n[u] <= wr_n[u] + 1;
            end
            if (reset[u] || !dec_start[u] || dec_finish[u]) begin
                dec_finish[u] <= 1'b0;
                dcnt[u]       <= 0;
            end else if (dcnt[u] >= dly[u] - 1) begin
                dec_finish[u] <= 1'b1;
                dcnt[u]       <= 0;
            end else begin
                dcnt[u] <= dcnt[u] + 1;
            end
        end
    end

    // observation away from the active edge
    int         cyc = 0;
    int         fin_n [NI] = '{0, 0, 0};
    int         wren_n [NI] = '{0, 0, 0};
    int         rise_n [NI] = '{0, 0, 0};
    int         rise_cyc [NI][1024];
    int         rw_err [NI] = '{0, 0, 0};
    int         stab_err [NI] = '{0, 0, 0};
    int         sacc_err [NI] = '{0, 0, 0};
    int         cur_len [NI] = '{0, 0, 0};
    int         last_len [NI] = '{0, 0, 0};
    logic       ds_prev [NI] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] hold_adr [NI];
    logic [7:0] hold_dat [NI];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < NI; u++) begin
            if (finish[u]) fin_n[u] <= fin_n[u] + 1;
            if (s_wren[u]) wren_n[u] <= wren_n[u] + 1;
            if (dec_rw[u] !== dec_start[u]) rw_err[u] <= rw_err[u] + 1;
            if (dec_start[u]) begin
                if (s_wren[u]) sacc_err[u] <= sacc_err[u] + 1;
                if (!ds_prev[u]) begin
                    hold_adr[u] <= dec_adr[u];
                    hold_dat[u] <= dec_wdata[u];
                    rise_cyc[u][rise_n[u] % 1024] <= cyc;
                    rise_n[u]  <= rise_n[u] + 1;
                    cur_len[u] <= 1;
                end else begin
                    if (dec_adr[u] !== hold_adr[u] || dec_wdata[u] !== hold_dat[u])
                        stab_err[u] <= stab_err[u] + 1;
                    cur_len[u] <= cur_len[u] + 1;
                end
            end else if (ds_prev[u]) begin
                last_len[u] <= cur_len[u];
            end
            ds_prev[u] <= dec_start[u];
        end
    end

    // reference model and checking
    int         ms [NI][256];
    logic [7:0] exp_pt [256];
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [43:0] outs(input int u);
        return {finish[u], s_adr[u], s_wren[u], s_wdata[u], rom_adr[u],
                dec_start[u], dec_rw[u], dec_adr[u], dec_wdata[u]};
    endfunction

    // textbook RC4 PRGA on the model S box, i and j restarting at 0
    task automatic rc4_ref(input int u, input int n);
        int i, j, t;
        i = 0;
        j = 0;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + ms[u][i]) % 256;
            t = ms[u][i];
            ms[u][i] = ms[u][j];
            ms[u][j] = t;
            exp_pt[k] = rom[u][k] ^ 8'(ms[u][(ms[u][i] + ms[u][j]) % 256]);
        end
    endtask

    task automatic load_s(input int u);
        for (int a = 0; a < 256; a++) init_s[u][a] = 8'(ms[u][a]);
        load[u] = 1'b1;
        @(negedge clk);
        load[u] = 1'b0;
    endtask

    task automatic do_run(input int u, input int n, input bit poke, input string tag);
        int w0, f0, t;
        w0 = wr_n[u];
        f0 = fin_n[u];
        rc4_ref(u, n);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        t = 0;
        while (fin_n[u] == f0 && t < n * 40 + 100) begin
            start[u] = poke && (t == 4 || t == 11 || t == 17);
            @(negedge clk);
            t++;
        end
        start[u] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq({tag, "_fin"}, fin_n[u] - f0, 1);
        check_eq({tag, "_nwr"}, wr_n[u] - w0, n);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_adr%0d", tag, k), wr_adr[u][(w0 + k) % 1024], k);
            check_eq($sformatf("%s_dat%0d", tag, k), wr_dat[u][(w0 + k) % 1024], exp_pt[k]);
        end
    endtask

    initial begin
        int r0, w0, wn, t, b, tmp, d;
        bit prev, hit;
        for (int u = 0; u < NI; u++) begin
            reset[u] = 1'b1;
            start[u] = 1'b0;
            load[u]  = 1'b0;
            for (int a = 0; a < 256; a++) begin
                ms[u][a]  = a;
                rom[u][a] = 8'h00;
            end
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NI; u++) check_eq($sformatf("rst_outs%0d", u), outs(u), 0);
        for (int u = 0; u < NI; u++) reset[u] = 1'b0;

        // identity S, known ciphertext
        for (int u = 0; u < 2; u++) begin
            rom[u][0] = 8'h41;
            rom[u][1] = 8'h00;
            rom[u][2] = 8'h10;
            load_s(u);
        end
        r0 = rise_n[0];
        w0 = wr_n[0];
        do_run(0, 3, 1'b0, "id");
        check_eq("id_b0", wr_dat[0][w0 % 1024], 8'h43);
        check_eq("id_b1", wr_dat[0][(w0 + 1) % 1024], 8'h05);
        check_eq("id_b2", wr_dat[0][(w0 + 2) % 1024], 8'h17);
        check_eq("id_s2", smem[0][2], 3);
        check_eq("id_s3", smem[0][3], 5);
        check_eq("id_s5", smem[0][5], 2);
        check_eq("id_period", rise_cyc[0][(r0 + 1) % 1024] - rise_cyc[0][r0 % 1024], 10);

        r0 = rise_n[1];
        w0 = wr_n[1];
        do_run(1, 3, 1'b0, "rl3");
        check_eq("rl3_b0", wr_dat[1][w0 % 1024], 8'h43);
        check_eq("rl3_b2", wr_dat[1][(w0 + 2) % 1024], 8'h17);
        check_eq("rl3_period", rise_cyc[1][(r0 + 1) % 1024] - rise_cyc[1][r0 % 1024], 16);

        // slow interface: request held 8 cycles
        dly[0] = 7;
        do_run(0, 3, 1'b0, "slow");
        check_eq("slow_len", last_len[0], 8);

        // random ciphertext and handshake delay, start poked while busy
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 256; a++) rom[0][a] = 8'($urandom);
            dly[0] = $urandom_range(1, 5);
            do_run(0, 3, 1'b1, $sformatf("rnd%0d", r));
        end

        // reset during WR_I of byte 1
        dly[0] = 2;
        w0 = wr_n[0];
        t = 0;
        prev = 1'b0;
        hit = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (!hit && t < 300) begin
            @(negedge clk);
            t++;
            hit = s_wren[0] && prev && (wr_n[0] - w0 == 1);
            prev = s_wren[0];
        end
        check_eq("abort_hit", hit, 1);
        reset[0] = 1'b1;
        rc4_ref(0, 2);
        @(negedge clk);
        check_eq("abort_outs", outs(0), 0);
        wn = wren_n[0];
        r0 = rise_n[0];
        @(negedge clk);
        reset[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("abort_nowren", wren_n[0] - wn, 0);
        check_eq("abort_nodec", rise_n[0] - r0, 0);
        do_run(0, 3, 1'b0, "rerun");

        // full 256-byte message, all-zero ciphertext, shuffled S
        for (int a = 255; a > 0; a--) begin
            b = $urandom_range(0, a);
            tmp = ms[2][a];
            ms[2][a] = ms[2][b];
            ms[2][b] = tmp;
        end
        load_s(2);
        do_run(2, 256, 1'b0, "m256");

        for (int u = 0; u < NI; u++) begin
            d = 0;
            for (int a = 0; a < 256; a++) if (smem[u][a] !== 8'(ms[u][a])) d++;
            check_eq($sformatf("sbox%0d", u), d, 0);
            check_eq($sformatf("rw%0d", u), rw_err[u], 0);
            check_eq($sformatf("stable%0d", u), stab_err[u], 0);
            check_eq($sformatf("s_idle%0d", u), sacc_err[u], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
